spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave with a one-byte transmit holding buffer.
// ss_n, sck and mosi are oversampled through SYNC_STAGES-deep synchronizers
// and every transfer action is taken in the clk domain on detected sck edges.
// Optional feature: define SPI_SLAVE_UNDERRUN_EN to enable tx_underrun pulses;
// without it the tx_underrun port is tied low.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       tx_underrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } stateT;

    stateT r_state;
    stateT w_stateNext;

    logic [SYNC_STAGES-1:0] r_ssSync;
    logic [SYNC_STAGES-1:0] r_sckSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_ssPrev;
    logic                   r_sckPrev;

    logic w_ss;
    logic w_sck;
    logic w_mosi;
    logic w_ssFall;
    logic w_sckRiseRaw;
    logic w_sckFallRaw;

    logic w_enter;
    logic w_leave;
    logic w_sample;
    logic w_shiftTx;
    logic w_byteStart;

    logic [7:0] r_txBuf;
    logic       r_txFull;
    logic [7:0] r_txShift;
    logic [7:0] r_rxShift;
    logic [2:0] r_bitCnt;
    logic [7:0] r_rxData;
    logic       r_rxValid;
    logic       r_misoOe;
    logic [7:0] w_loadValue;

    assign w_ss         = r_ssSync[SYNC_STAGES-1];
    assign w_sck        = r_sckSync[SYNC_STAGES-1];
    assign w_mosi       = r_mosiSync[SYNC_STAGES-1];
    assign w_ssFall     = r_ssPrev & ~w_ss;
    assign w_sckRiseRaw = w_sck & ~r_sckPrev;
    assign w_sckFallRaw = ~w_sck & r_sckPrev;

    // An empty holding buffer sends zeros for the whole byte
    assign w_loadValue  = r_txFull ? r_txBuf : 8'h00;

    assign miso     = r_txShift[7];
    assign miso_oe  = r_misoOe;
    assign tx_ready = ~r_txFull;
    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;
    assign busy     = (r_state == ACTIVE);

    // Bring the asynchronous SPI pins into the clk domain and keep delayed copies for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ssSync   <= '0;
            r_sckSync  <= '0;
            r_mosiSync <= '0;
            r_ssPrev   <= 1'b0;
            r_sckPrev  <= 1'b0;
        end else begin
            r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], ss_n};
            r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], sck};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
            r_ssPrev   <= w_ss;
            r_sckPrev  <= w_sck;
        end
    end

    // State register; the previous-ss copy resets low so a held-low ss_n cannot start a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and per-cycle action strobes; sck edges only matter while selected
    always_comb begin
        w_stateNext = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        w_sample    = 1'b0;
        w_shiftTx   = 1'b0;
        w_byteStart = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ssFall) begin
                    w_stateNext = ACTIVE;
                    w_enter     = 1'b1;
                    w_byteStart = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss) begin
                    w_stateNext = IDLE;
                    w_leave     = 1'b1;
                end else begin
                    w_sample = w_sckRiseRaw;
                    if (w_sckFallRaw) begin
                        if (r_bitCnt == 3'd0) begin
                            w_byteStart = 1'b1;
                        end else begin
                            w_shiftTx = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and received-byte output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txShift <= 8'h00;
            r_rxShift <= 8'h00;
            r_bitCnt  <= 3'd0;
            r_rxData  <= 8'h00;
            r_rxValid <= 1'b0;
            r_misoOe  <= 1'b0;
        end else begin
            r_rxValid <= 1'b0;
            if (w_leave) begin
                r_txShift <= 8'h00;
                r_rxShift <= 8'h00;
                r_bitCnt  <= 3'd0;
                r_misoOe  <= 1'b0;
            end else begin
                if (w_byteStart) begin
                    r_txShift <= w_loadValue;
                    if (w_enter) begin
                        r_bitCnt <= 3'd0;
                        r_misoOe <= 1'b1;
                    end
                end else if (w_shiftTx) begin
                    r_txShift <= {r_txShift[6:0], 1'b0};
                end
                if (w_sample) begin
                    r_rxShift <= {r_rxShift[6:0], w_mosi};
                    r_bitCnt  <= r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        r_rxData  <= {r_rxShift[6:0], w_mosi};
                        r_rxValid <= 1'b1;
                    end
                end
            end
        end
    end

    // One-byte holding buffer: a load racing an empty-buffer byte start lands for the following byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txBuf  <= 8'h00;
            r_txFull <= 1'b0;
        end else begin
            if (w_byteStart && r_txFull) begin
                r_txFull <= 1'b0;
            end
            if (tx_load && !r_txFull) begin
                r_txBuf  <= tx_data;
                r_txFull <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic r_underrun;

    // Flag every byte start that found nothing to send
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_byteStart & ~r_txFull;
        end
    end

    assign tx_underrun = r_underrun;
`else
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: a mode-0 master drives frames while a monitor
// checks every rx_valid against a queue of expected bytes. The holding buffer
// is modelled as "full flag + value"; each byte start takes its content or
// sends zeros. Honours SPI_SLAVE_UNDERRUN_EN when counting underrun pulses.
module tb_spi_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] expRxQ[$];
    logic [7:0] frameBytes[$];
    logic [7:0] monExp;

    bit         modelFull;
    logic [7:0] modelBuf;
    logic [7:0] modelLastRx;
    int         modelUnderruns;
    int         seenUnderruns;

    // 10 ns system clock
    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss_n       (ss_n),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A byte start hands over the buffered byte, or zeros when nothing is waiting
    function automatic logic [7:0] modelByteStart();
        logic [7:0] v;
        if (modelFull) begin
            v         = modelBuf;
            modelFull = 1'b0;
        end else begin
            v = 8'h00;
            modelUnderruns++;
        end
        return v;
    endfunction

    task automatic loadByte(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        if (!modelFull) begin
            modelFull = 1'b1;
            modelBuf  = d;
        end
        @(negedge clk);
        tx_load = 1'b0;
        checkOutput("tx_ready after load", tx_ready, !modelFull);
    endtask

    task automatic checkResetState();
        checkOutput("reset miso", miso, 0);
        checkOutput("reset miso_oe", miso_oe, 0);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset tx_underrun", tx_underrun, 0);
        checkOutput("reset tx_ready", tx_ready, 1);
    endtask

    // One master frame of nBits clocks; bytes come from frameBytes, else random
    task automatic applyStimulus(input int nBits, input bit midLoad, input logic [7:0] midVal);
        logic [7:0] curMosi;
        logic [7:0] expMiso;
        logic [7:0] gotMiso;
        int         bi;
        curMosi = 8'h00;
        gotMiso = 8'h00;
        @(negedge clk);
        ss_n    = 1'b0;
        expMiso = modelByteStart();
        waitClk(8);
        for (int b = 0; b < nBits; b++) begin
            bi = 7 - (b % 8);
            if (b % 8 == 0) begin
                curMosi = (frameBytes.size() > 0) ? frameBytes.pop_front() : 8'($urandom);
                gotMiso = 8'h00;
            end
            mosi = curMosi[bi];
            waitClk(HALF);
            sck = 1'b1;
            gotMiso[bi] = miso;
            if (b == 0) begin
                checkOutput("busy in frame", busy, 1);
                checkOutput("miso_oe in frame", miso_oe, 1);
            end
            if (b % 8 == 7) begin
                expRxQ.push_back(curMosi);
                modelLastRx = curMosi;
            end
            if (midLoad && b == 3) begin
                loadByte(midVal);
            end
            waitClk(HALF);
            sck = 1'b0;
            if (b % 8 == 7) begin
                checkOutput("miso byte", gotMiso, expMiso);
                expMiso = modelByteStart();
            end
        end
        waitClk(HALF);
        ss_n = 1'b1;
        waitClk(10);
        checkOutput("busy after frame", busy, 0);
        checkOutput("miso_oe after frame", miso_oe, 0);
        checkOutput("rx_data held", rx_data, modelLastRx);
    endtask

    // Monitor: every rx_valid must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (expRxQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected rx_valid: rx_data 0x%0h, no byte expected", rx_data);
                end else begin
                    monExp = expRxQ.pop_front();
                    checkOutput("rx_data", rx_data, monExp);
                end
            end
            if (tx_underrun) begin
                seenUnderruns++;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, run did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random frames
    initial begin
        rst            = 1'b1;
        ss_n           = 1'b1;
        sck            = 1'b0;
        mosi           = 1'b0;
        tx_load        = 1'b0;
        tx_data        = 8'h00;
        modelFull      = 1'b0;
        modelBuf       = 8'h00;
        modelLastRx    = 8'h00;
        modelUnderruns = 0;
        seenUnderruns  = 0;

        waitClk(3);
        checkResetState();
        @(negedge clk);
        rst = 1'b0;
        waitClk(5);

        // Single byte with preloaded buffer
        loadByte(8'hA5);
        frameBytes.push_back(8'h3C);
        applyStimulus(8, 1'b0, 8'h00);
        checkOutput("tx_ready after single byte", tx_ready, 1);

        // Two bytes, second tx byte loaded during the first
        loadByte(8'h55);
        frameBytes.push_back(8'h01);
        frameBytes.push_back(8'h80);
        applyStimulus(16, 1'b1, 8'hF0);

        // Empty buffer sends zeros
        frameBytes.push_back(8'hFF);
        applyStimulus(8, 1'b0, 8'h00);

        // Aborted frame after five clocks, then a full one
        applyStimulus(5, 1'b0, 8'h00);
        frameBytes.push_back(8'h81);
        applyStimulus(8, 1'b0, 8'h00);

        // Second load while full is ignored
        loadByte(8'h11);
        loadByte(8'h22);
        applyStimulus(8, 1'b0, 8'h00);

        // Reset in the middle of a byte
        @(negedge clk);
        ss_n = 1'b0;
        void'(modelByteStart());
        waitClk(8);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'($urandom);
            waitClk(HALF);
            sck = 1'b1;
            waitClk(HALF);
            sck = 1'b0;
        end
        waitClk(2);
        rst = 1'b1;
        waitClk(2);
        checkResetState();
        modelFull   = 1'b0;
        modelLastRx = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        waitClk(6);
        checkOutput("busy after reset with ss_n low", busy, 0);
        ss_n = 1'b1;
        waitClk(8);
        frameBytes.push_back(8'hC3);
        applyStimulus(8, 1'b0, 8'h00);

        // Random frames
        for (int i = 0; i < 15; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                loadByte(8'($urandom));
            end
            applyStimulus(8 * int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        waitClk(10);
        checkOutput("scoreboard drained", expRxQ.size(), 0);
`ifdef SPI_SLAVE_UNDERRUN_EN
        checkOutput("underrun pulses", seenUnderruns, modelUnderruns);
`else
        checkOutput("underrun pulses", seenUnderruns, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
